mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single CPU memory bus between NREQ requesters: port 0 = instruction fetch
//   (driven by the control unit in STATE_FETCH_INST), port 1 = data load/store (MEM
//   instructions), port 2 = debug/loader. It performs one transaction at a time, with
//   round-robin arbitration and a fixed-latency memory. It sits between the control unit
//   and the RAM/ROM.
// PARAMETERS
//   NREQ     3   number of requester ports (>=2)
//   ADDR_W   8   address width
//   DATA_W   8   data width
//   MEM_LAT  1   memory cycles per access (>=1); mem_en held this many cycles
// PORTS
//   clk        in   1             system clock, rising edge
//   reset      in   1             asynchronous, active-high
//   req        in   NREQ          per-port request, level
//   req_we     in   NREQ          per-port write enable (1=write, 0=read)
//   req_addr   in   NREQ*ADDR_W   packed addresses, port i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   NREQ*DATA_W   packed write data, same packing
//   gnt        out  NREQ          one-hot 1-cycle pulse: request accepted
//   done       out  NREQ          one-hot 1-cycle pulse: transaction complete
//   rdata      out  DATA_W        read data, valid while done!=0 (read transactions)
//   busy       out  1             transaction in progress (state!=IDLE)
//   mem_en     out  1             memory access strobe
//   mem_we     out  1             memory write
//   mem_addr   out  ADDR_W        memory address
//   mem_wdata  out  DATA_W        memory write data
//   mem_rdata  in   DATA_W        memory read data, valid on the last mem_en cycle
// BEHAVIOUR
//   - Reset (async): state=IDLE; gnt=0, done=0, rdata=0, busy=0, mem_en=0, mem_we=0,
//     mem_addr=0, mem_wdata=0; last-grant pointer=NREQ-1, so port 0 wins first.
//   - FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   - IDLE, at least one req high:
//     - Winner = first set req scanning from (ptr+1) mod NREQ upward with wrap.
//     - At the edge: latch id/we/addr/wdata, ptr<=id, gnt[id]<=1 for one cycle,
//       state<=ACCESS, wait counter<=MEM_LAT-1.
//     - No req: stay in IDLE, all strobes 0.
//   - ACCESS:
//     - mem_en=1 and mem_we/addr/wdata = latched values, stable for exactly MEM_LAT cycles.
//     - Counter decrements each cycle; at 0, mem_rdata is captured into rdata (reads only)
//       and state<=RESP.
//   - RESP:
//     - done[id]=1 for one cycle, mem_en=0, state<=IDLE.
//     - rdata holds its value until the next read completes.
//     - Writes leave rdata unchanged.
//   - Timing and throughput:
//     - Request latency: req seen in IDLE at cycle N -> gnt at N+1, mem_en at N+1..N+MEM_LAT,
//       done at N+MEM_LAT+1.
//     - One transaction per MEM_LAT+2 cycles.
//   - Requester rules:
//     - req/we/addr/wdata are sampled only in IDLE; they may change after gnt.
//     - A req dropped before it is granted is withdrawn, with no side effect.
//     - req is ignored in ACCESS/RESP.
//     - A req still high when IDLE is re-entered is a new request and is arbitrated normally.
//   - Simultaneous requests: round-robin guarantees each waiting port is granted within
//     NREQ transactions; no starvation.
//   - Ports >= NREQ do not exist. The ptr wrap uses the modulo NREQ, not a power of 2.
//   - Reset mid-transaction: all outputs clear immediately and no done is issued; the
//     requester must re-issue.
//   - gnt and done are one-hot or zero at all times; gnt and done are never high in the
//     same cycle.
// TESTING
//   - Reset values: assert reset mid-ACCESS -> mem_en=0, busy=0 asynchronously, no done.
//     Release reset, raise req=3'b111 -> gnt=3'b001 first.
//   - Single read, MEM_LAT=1:
//     - Stimulus: req[0]=1, addr=8'h10, memory returns 8'hA5.
//     - Response: gnt[0] at N+1; mem_en=1, mem_addr=8'h10 at N+1; done[0] and rdata=8'hA5
//       at N+2.
//   - Write, MEM_LAT=3:
//     - Stimulus: req[1]=1, we=1, addr=8'h20, wdata=8'h5C.
//     - Response: mem_en=mem_we=1 for exactly 3 cycles; done[1] one cycle later;
//       rdata unchanged.
//   - Round-robin: hold req=3'b111 for 6 transactions -> grant order 0,1,2,0,1,2.
//     Then req=3'b101 after granting 0 -> next grant is 2.
//   - Withdrawal: req[2] raised during port-0 ACCESS, dropped before IDLE -> port 2 never
//     granted, busy falls after RESP.
//   - Back-to-back: req[0] held continuously -> gnt[0] every MEM_LAT+2 cycles, done[0]
//     between, gnt/done never coincide.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one fixed-latency memory bus between NREQ requesters.
// One transaction runs at a time: IDLE (arbitrate) -> ACCESS (MEM_LAT cycles) -> RESP (done pulse).
module mem_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     winner;
    logic                found;

    logic [ID_W-1:0]     cur_id;
    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [CNT_W-1:0]    cnt;
    logic [NREQ-1:0]     gnt_q;

    // Scan from the port after the last winner, wrapping modulo NREQ (not a power of two).
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ACCESS;
            ACCESS:  if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requester inputs are sampled only on the IDLE->ACCESS edge; afterwards they may change freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= ID_W'(NREQ - 1);
            cur_id    <= '0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cnt       <= '0;
            gnt_q     <= '0;
            rdata     <= '0;
        end else begin
            gnt_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        ptr       <= winner;
                        cur_id    <= winner;
                        cur_we    <= req_we[winner];
                        cur_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                        cur_wdata <= req_wdata[int'(winner)*DATA_W +: DATA_W];
                        cnt       <= CNT_W'(MEM_LAT - 1);
                        gnt_q     <= NREQ'(1) << winner;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!cur_we) begin
                        rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus strobes come straight from the state so an async reset clears them immediately.
    always_comb begin
        gnt       = gnt_q;
        busy      = (state != IDLE);
        mem_en    = (state == ACCESS);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = '0;
        if (state == ACCESS) begin
            mem_we    = cur_we;
            mem_addr  = cur_addr;
            mem_wdata = cur_wdata;
        end
        if (state == RESP) begin
            done = NREQ'(1) << cur_id;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3 share the requester inputs,
// each backed by its own behavioural memory; a round-robin reference model checks random traffic.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  req_we = '0;
    logic [23:0] req_addr = '0;
    logic [23:0] req_wdata = '0;

    logic [2:0]  gnt1, done1, gnt3, done3;
    logic [7:0]  rdata1, rdata3;
    logic        busy1, busy3, mem_en1, mem_en3, mem_we1, mem_we3;
    logic [7:0]  mem_addr1, mem_addr3, mem_wdata1, mem_wdata3, mem_rdata1, mem_rdata3;

    int checks = 0;
    int errors = 0;

    bit [7:0] mem1 [256];
    bit       wr1  [256];
    bit [7:0] mem3 [256];
    bit       wr3  [256];

    bit [7:0] ref_mem   [256];
    bit       ref_valid [256];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.NREQ(3), .ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt1), .done(done1), .rdata(rdata1), .busy(busy1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    mem_bus_arbiter #(.NREQ(3), .ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt3), .done(done3), .rdata(rdata3), .busy(busy3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h3C);
    endfunction

    function automatic int onehot_idx(input logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    assign mem_rdata1 = wr1[mem_addr1] ? mem1[mem_addr1] : init_val(mem_addr1);
    assign mem_rdata3 = wr3[mem_addr3] ? mem3[mem_addr3] : init_val(mem_addr3);

    always @(posedge clk) begin
        if (mem_en1 && mem_we1) begin
            mem1[mem_addr1] <= mem_wdata1;
            wr1[mem_addr1]  <= 1'b1;
        end
        if (mem_en3 && mem_we3) begin
            mem3[mem_addr3] <= mem_wdata3;
            wr3[mem_addr3]  <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = '0;
        req_we = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done3(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done3 != 3'b000) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt3, done3, busy3, mem_en3, mem_we3} !== 9'b0 || mem_addr3 !== 8'h00 ||
            mem_wdata3 !== 8'h00 || rdata3 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_values: got gnt=%b done=%b busy=%b en=%b addr=%h rdata=%h expected all zero",
                     gnt3, done3, busy3, mem_en3, mem_addr3, rdata3);
        end
        req_addr[7:0] = 8'h44;
        req = 3'b001;
        step();
        checks++;
        if (mem_en3 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pre_access: got mem_en=%b expected 1", mem_en3);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_en3 !== 1'b0 || busy3 !== 1'b0 || gnt3 !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_async_clear: got en=%b busy=%b gnt=%b expected 0 0 000",
                     mem_en3, busy3, gnt3);
        end
        req = 3'b111;
        step();
        checks++;
        if (done3 !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got done=%b expected 000", done3);
        end
        reset = 1'b0;
        step();
        checks++;
        if (gnt3 !== 3'b001 || gnt1 !== 3'b001) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got gnt3=%b gnt1=%b expected 001", gnt3, gnt1);
        end
        req = '0;
    endtask

    task automatic test_single_read();
        do_reset();
        req_addr[7:0] = 8'h10;
        req_we = 3'b000;
        req = 3'b001;
        step();
        checks++;
        if (gnt1 !== 3'b001 || mem_en1 !== 1'b1 || mem_addr1 !== 8'h10 || done1 !== 3'b000) begin
            errors++;
            $display("[TB] FAIL read_access: got gnt=%b en=%b addr=%h done=%b expected 001 1 10 000",
                     gnt1, mem_en1, mem_addr1, done1);
        end
        req = '0;
        step();
        checks++;
        if (done1 !== 3'b001 || rdata1 !== 8'hA5 || gnt1 !== 3'b000 || mem_en1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_done: got done=%b rdata=%h gnt=%b en=%b expected 001 a5 000 0",
                     done1, rdata1, gnt1, mem_en1);
        end
    endtask

    task automatic test_write();
        bit ok;
        int en_cnt, last_en, done_cyc;
        logic [7:0] rdata_done;
        do_reset();
        req_addr[7:0] = 8'h10;
        req = 3'b001;
        step();
        req = '0;
        wait_done3(8, ok);
        checks++;
        if (!ok || rdata3 !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL write_preread: got ok=%0d rdata=%h expected 1 a5", ok, rdata3);
        end
        step();
        req_addr[15:8]  = 8'h20;
        req_wdata[15:8] = 8'h5C;
        req_we = 3'b010;
        req = 3'b010;
        en_cnt = 0;
        last_en = -1;
        done_cyc = -1;
        rdata_done = 8'hxx;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 0) begin
                req = '0;
                req_we = '0;
            end
            if (mem_en3 && mem_we3 && mem_addr3 == 8'h20 && mem_wdata3 == 8'h5C) begin
                en_cnt++;
                last_en = c;
            end
            if (done3 == 3'b010 && done_cyc < 0) begin
                done_cyc = c;
                rdata_done = rdata3;
            end
        end
        checks++;
        if (en_cnt != 3) begin
            errors++;
            $display("[TB] FAIL write_strobe_len: got %0d cycles expected 3", en_cnt);
        end
        checks++;
        if (done_cyc != last_en + 1 || last_en != 2) begin
            errors++;
            $display("[TB] FAIL write_done_timing: got done at %0d last_en %0d expected 3 and 2",
                     done_cyc, last_en);
        end
        checks++;
        if (rdata_done !== 8'hA5 || rdata3 !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL write_rdata_kept: got %h/%h expected a5", rdata_done, rdata3);
        end
        ref_mem[8'h20]   = 8'h5C;
        ref_valid[8'h20] = 1'b1;
    endtask

    task automatic test_round_robin();
        int gq[$];
        bit seen;
        logic [2:0] got;
        do_reset();
        req_we = '0;
        req = 3'b111;
        for (int c = 0; c < 60 && gq.size() < 6; c++) begin
            step();
            if (gnt3 != 3'b000) gq.push_back(onehot_idx(gnt3));
        end
        checks++;
        if (gq.size() != 6) begin
            errors++;
            $display("[TB] FAIL rr_grant_count: got %0d expected 6", gq.size());
        end
        for (int i = 0; i < gq.size(); i++) begin
            checks++;
            if (gq[i] != i % 3) begin
                errors++;
                $display("[TB] FAIL rr_order[%0d]: got port %0d expected port %0d", i, gq[i], i % 3);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (gnt3 == 3'b001) begin
                seen = 1'b1;
                break;
            end
        end
        req = 3'b101;
        got = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (gnt3 != 3'b000) begin
                got = gnt3;
                break;
            end
        end
        checks++;
        if (!seen || got !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rr_skip: got seen0=%0d next gnt=%b expected 1 100", seen, got);
        end
        req = '0;
        step();
        step();
        step();
        step();
    endtask

    task automatic test_withdrawal();
        int gnt2_cnt, done_cyc, idle_cyc;
        do_reset();
        req = 3'b001;
        step();
        req = 3'b100;
        step();
        req = 3'b000;
        gnt2_cnt = 0;
        done_cyc = -1;
        idle_cyc = -1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt3[2]) gnt2_cnt++;
            if (done3 == 3'b001 && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 1 && !busy3) idle_cyc = c;
        end
        checks++;
        if (gnt2_cnt != 0) begin
            errors++;
            $display("[TB] FAIL withdraw_no_grant: got %0d grants to port 2 expected 0", gnt2_cnt);
        end
        checks++;
        if (done_cyc != 1 || idle_cyc != 2) begin
            errors++;
            $display("[TB] FAIL withdraw_busy_fall: got done at %0d idle at %0d expected 1 and 2",
                     done_cyc, idle_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int q1[$];
        int q3[$];
        int overlap, dones_between;
        do_reset();
        req_we = '0;
        req_addr[7:0] = 8'h33;
        req = 3'b001;
        overlap = 0;
        dones_between = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (gnt1[0]) q1.push_back(c);
            if (gnt3[0]) q3.push_back(c);
            if ((gnt1 & done1) != 0 || (gnt3 & done3) != 0) overlap++;
            if (done3[0] && q3.size() > 0 && q3.size() < 7) dones_between++;
        end
        req = '0;
        checks++;
        if (q3.size() < 7 || q1.size() < 10) begin
            errors++;
            $display("[TB] FAIL b2b_grant_count: got %0d/%0d expected >=7/>=10", q3.size(), q1.size());
        end
        for (int i = 1; i < q3.size(); i++) begin
            checks++;
            if (q3[i] - q3[i-1] != 5) begin
                errors++;
                $display("[TB] FAIL b2b_spacing3[%0d]: got %0d expected 5", i, q3[i] - q3[i-1]);
            end
        end
        for (int i = 1; i < q1.size(); i++) begin
            checks++;
            if (q1[i] - q1[i-1] != 3) begin
                errors++;
                $display("[TB] FAIL b2b_spacing1[%0d]: got %0d expected 3", i, q1[i] - q1[i-1]);
            end
        end
        checks++;
        if (overlap != 0 || dones_between != 6) begin
            errors++;
            $display("[TB] FAIL b2b_done_pattern: got overlap=%0d dones=%0d expected 0 6",
                     overlap, dones_between);
        end
        step();
        step();
        step();
        step();
    endtask

    task automatic test_random();
        int ref_ptr, w, bestd, d, en_cnt, en_bad;
        logic [7:0] ref_rdata, a, wd, exp_rdata;
        logic [2:0] r;
        bit we, got_done;
        do_reset();
        ref_ptr = 2;
        ref_rdata = 8'h00;
        for (int t = 0; t < 40; t++) begin
            r = 3'($urandom_range(0, 7));
            req_we = 3'($urandom);
            req_addr = 24'($urandom);
            req_wdata = 24'($urandom);
            req = r;
            step();
            if (r == 3'b000) begin
                checks++;
                if (gnt3 !== 3'b000 || busy3 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_idle[%0d]: got gnt=%b busy=%b expected 000 0", t, gnt3, busy3);
                end
                continue;
            end
            w = -1;
            bestd = 99;
            for (int i = 0; i < 3; i++) begin
                d = (i - ref_ptr - 1 + 6) % 3;
                if (r[i] && d < bestd) begin
                    bestd = d;
                    w = i;
                end
            end
            ref_ptr = w;
            we = req_we[w];
            a  = req_addr[w*8 +: 8];
            wd = req_wdata[w*8 +: 8];
            if (we) begin
                ref_mem[a] = wd;
                ref_valid[a] = 1'b1;
                exp_rdata = ref_rdata;
            end else begin
                exp_rdata = ref_valid[a] ? ref_mem[a] : init_val(a);
                ref_rdata = exp_rdata;
            end
            checks++;
            if (gnt3 !== 3'(1 << w)) begin
                errors++;
                $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", t, gnt3, 3'(1 << w));
            end
            req = 3'($urandom);
            req_we = 3'($urandom);
            req_addr = 24'($urandom);
            req_wdata = 24'($urandom);
            en_cnt = 0;
            en_bad = 0;
            got_done = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (mem_en3) begin
                    en_cnt++;
                    if (mem_we3 !== we || mem_addr3 !== a || (we && mem_wdata3 !== wd)) en_bad++;
                end
                if (done3 != 3'b000) begin
                    got_done = 1'b1;
                    break;
                end
                step();
            end
            checks++;
            if (!got_done || en_cnt != 3 || en_bad != 0 || done3 !== 3'(1 << w) || rdata3 !== exp_rdata) begin
                errors++;
                $display("[TB] FAIL rand_txn[%0d]: got done=%b en=%0d bad=%0d rdata=%h expected done=%b en=3 bad=0 rdata=%h",
                         t, done3, en_cnt, en_bad, rdata3, 3'(1 << w), exp_rdata);
            end
            req = '0;
            step();
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_withdrawal();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
